// File: rtl/inst_cache_pkg.sv
// Shared widths, state encoding and defaults for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;
  localparam int INDEX_W_DEF = 7;

  typedef logic [INST_W-1:0]      inst_bus_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } cache_state_e;

  localparam logic [2:0] BYTES_PER_LINE = 3'd4;

endpackage

// File: rtl/inst_cache_ram.sv
// Tag/valid/data array: combinational lookup, synchronous line write and valid clear.
module inst_cache_ram
  import inst_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = INDEX_W_DEF,
  parameter int TAG_WIDTH   = INST_ADDR_W - INDEX_W_DEF - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] waddr,
  input  logic [TAG_WIDTH-1:0]   wtag,
  input  inst_bus_t              wdata,
  input  logic [INDEX_WIDTH-1:0] raddr,
  output logic                   rvalid,
  output logic [TAG_WIDTH-1:0]   rtag,
  output inst_bus_t              rdata
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   valid_d;
  logic [TAG_WIDTH-1:0] tag_q [LINES];
  inst_bus_t          data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[waddr]  <= wtag;
      data_q[waddr] <= wdata;
    end
  end

  assign rvalid = valid_q[raddr];
  assign rtag   = tag_q[raddr];
  assign rdata  = data_q[raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache; misses refill one 32-bit line through a byte-serial read port.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = INDEX_W_DEF,
  parameter int ADDR_WIDTH  = INST_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  output logic                  hit_o,
  output inst_bus_t             inst_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_busy_i,
  input  logic [7:0]            mem_byte_i
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

  cache_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_pc_q, fill_pc_d;
  logic [2:0]            issue_cnt_q, issue_cnt_d;
  logic [2:0]            recv_cnt_q, recv_cnt_d;
  logic                  pend_q, pend_d;
  inst_bus_t             line_buf_q, line_buf_d;

  logic                   accept;
  logic                   line_we;
  logic                   ram_valid;
  logic [TAG_W-1:0]       ram_tag;
  inst_bus_t              ram_data;
  logic [INDEX_WIDTH-1:0] lookup_index;
  logic [TAG_W-1:0]       lookup_tag;
  logic                   unused_pc_bits;

  assign lookup_index   = pc_i[INDEX_WIDTH+1:2];
  assign lookup_tag     = pc_i[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_pc_bits = ^pc_i[1:0];

  inst_cache_ram #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (line_we & ~rst),
    .waddr  (fill_pc_q[INDEX_WIDTH+1:2]),
    .wtag   (fill_pc_q[ADDR_WIDTH-1:INDEX_WIDTH+2]),
    .wdata  (line_buf_d),
    .raddr  (lookup_index),
    .rvalid (ram_valid),
    .rtag   (ram_tag),
    .rdata  (ram_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fill_pc_q   <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pend_q      <= 1'b0;
      line_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_pc_q   <= fill_pc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pend_q      <= pend_d;
      line_buf_q  <= line_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_pc_d   = fill_pc_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    pend_d      = accept;
    line_buf_d  = line_buf_q;
    line_we     = 1'b0;

    // A byte accepted last cycle is captured even while rdy_i is low.
    if (pend_q) begin
      line_buf_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_byte_i;
      recv_cnt_d = recv_cnt_q + 3'd1;
    end
    if (accept) issue_cnt_d = issue_cnt_q + 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (req_i && !hit_o && !flush_i && rdy_i) begin
          fill_pc_d   = {pc_i[ADDR_WIDTH-1:2], 2'b00};
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (rdy_i && recv_cnt_d == BYTES_PER_LINE) begin
          line_we     = 1'b1;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush discards the partial line and any byte still in flight.
    if (flush_i) begin
      state_d     = ST_IDLE;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
      pend_d      = 1'b0;
      line_we     = 1'b0;
    end
  end

  always_comb begin
    hit_o      = ~rst & req_i & (state_q == ST_IDLE) & ram_valid
               & (ram_tag == lookup_tag) & ~flush_i;
    inst_o     = hit_o ? ram_data : '0;
    mem_req_o  = ~rst & (state_q == ST_FILL) & (issue_cnt_q < BYTES_PER_LINE)
               & rdy_i & ~flush_i;
    mem_addr_o = mem_req_o ? fill_pc_q + ADDR_WIDTH'(issue_cnt_q) : '0;
    accept     = mem_req_o & ~mem_busy_i;
  end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: stimulus queues expected requests/hits, a monitor checks them.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_i;
  logic        req_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        hit_o;
  logic [31:0] inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_busy_i;
  logic [7:0]  mem_byte_i = 8'hEE;

  inst_cache dut (
    .clk        (clk),
    .rst        (rst),
    .rdy_i      (rdy_i),
    .req_i      (req_i),
    .pc_i       (pc_i),
    .flush_i    (flush_i),
    .hit_o      (hit_o),
    .inst_o     (inst_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_busy_i (mem_busy_i),
    .mem_byte_i (mem_byte_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t exp_mem[$];
  exp_t exp_hit[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  // Request schedules: nibble k (MSB first) is the byte offset requested in refill cycle k+1, F = none.
  localparam logic [63:0] SCHED_COLD  = 64'h0123_FFFF_FFFF_FFFF;
  localparam logic [63:0] SCHED_BUSY  = 64'h0122_223F_FFFF_FFFF;
  localparam logic [63:0] SCHED_PAUSE = 64'h01FF_23FF_FFFF_FFFF;

  localparam logic [31:0] INST_1000 = 32'hFF20_0413;
  localparam logic [31:0] INST_1200 = 32'h0010_0093;

  logic [7:0]  mem [0:65535];
  logic        acc_q = 1'b0;
  logic [31:0] acc_addr_q = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory controller model: byte valid the cycle after an accepted request, junk otherwise.
  always @(negedge clk) begin
    acc_q      <= (mem_req_o === 1'b1) && !mem_busy_i && rdy_i && !rst;
    acc_addr_q <= mem_addr_o;
  end

  always begin
    @(posedge clk);
    #1;
    mem_byte_i = acc_q ? mem[acc_addr_q[15:0]] : 8'hEE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_mem.size() > 0 && exp_mem[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL mem_req_missing: cycle %0d got none expected addr %h", exp_mem[0].cyc, exp_mem[0].val);
      void'(exp_mem.pop_front());
    end
    while (exp_hit.size() > 0 && exp_hit[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL hit_missing: cycle %0d got no hit expected inst %h", exp_hit[0].cyc, exp_hit[0].val);
      void'(exp_hit.pop_front());
    end
    if (mem_req_o === 1'b1) begin
      $display("cyc %0d mem_req addr=%h busy=%b", cyc, mem_addr_o, mem_busy_i);
      if (exp_mem.size() > 0 && exp_mem[0].cyc == cyc) begin
        e = exp_mem.pop_front();
        check("mem_addr", mem_addr_o, e.val);
      end else begin
        checks++;
        failures++;
        $display("FAIL mem_req_unexpected: cycle %0d got addr %h expected no request", cyc, mem_addr_o);
      end
    end
    if (hit_o === 1'b1) begin
      $display("cyc %0d hit pc=%h inst=%h", cyc, pc_i, inst_o);
      if (exp_hit.size() > 0 && exp_hit[0].cyc == cyc) begin
        e = exp_hit.pop_front();
        check("hit_inst", inst_o, e.val);
      end else begin
        checks++;
        failures++;
        $display("FAIL hit_unexpected: cycle %0d got inst %h expected miss", cyc, inst_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one refill of pc; busy and rdy-low windows are given in cycles relative to the miss.
  task automatic run_fill(input logic [31:0] pc, input logic [31:0] inst, input logic [63:0] sched,
                          input int hit_rel, input int busy_s, input int busy_n,
                          input int nrdy_s, input int nrdy_n);
    int         c;
    logic [3:0] nib;
    c     = cyc;
    req_i = 1'b1;
    pc_i  = pc;
    for (int k = 0; k <= hit_rel; k++) begin
      mem_busy_i = (k >= busy_s) && (k < busy_s + busy_n);
      rdy_i      = !((k >= nrdy_s) && (k < nrdy_s + nrdy_n));
      if (k >= 1 && k <= 16) begin
        nib = sched[63-4*(k-1) -: 4];
        if (nib != 4'hF) exp_mem.push_back('{c + k, pc + 32'(nib)});
      end
      if (k == hit_rel) exp_hit.push_back('{c + k, inst});
      step();
    end
    req_i      = 1'b0;
    mem_busy_i = 1'b0;
    rdy_i      = 1'b1;
  endtask

  initial begin
    int c;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'h1000] = 8'h13; mem[16'h1001] = 8'h04; mem[16'h1002] = 8'h20; mem[16'h1003] = 8'hFF;
    mem[16'h1200] = 8'h93; mem[16'h1201] = 8'h00; mem[16'h1202] = 8'h10; mem[16'h1203] = 8'h00;

    rst = 1'b1; rdy_i = 1'b1; req_i = 1'b0; flush_i = 1'b0; mem_busy_i = 1'b0; pc_i = '0;
    step(); step();
    rst = 1'b0;
    step();
    check("reset_hit_o", {31'b0, hit_o}, 32'h0);
    check("reset_inst_o", inst_o, 32'h0);
    check("reset_mem_req_o", {31'b0, mem_req_o}, 32'h0);
    check("reset_mem_addr_o", mem_addr_o, 32'h0);

    // Cold miss, then a same-cycle repeat hit.
    run_fill(32'h1000, INST_1000, SCHED_COLD, 6, -1, 0, -1, 0);
    req_i = 1'b1; pc_i = 32'h1000;
    exp_hit.push_back('{cyc, INST_1000});
    step();
    req_i = 1'b0;
    step();

    // Conflict on index 0: 0x1200 evicts 0x1000, which then misses again.
    run_fill(32'h1200, INST_1200, SCHED_COLD, 6, -1, 0, -1, 0);
    run_fill(32'h1000, INST_1000, SCHED_COLD, 6, -1, 0, -1, 0);

    // Reset two cycles into a refill of 0x1004.
    c = cyc;
    req_i = 1'b1; pc_i = 32'h1004;
    exp_mem.push_back('{c + 1, 32'h1004});
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; pc_i = 32'h1000;
    #1;
    check("post_reset_miss", {31'b0, hit_o}, 32'h0);

    // Contention: busy for three cycles while byte 2 is requested.
    run_fill(32'h1000, INST_1000, SCHED_BUSY, 9, 3, 3, -1, 0);

    // rdy_i low for two cycles mid-refill.
    run_fill(32'h1200, INST_1200, SCHED_PAUSE, 8, -1, 0, 3, 2);

    // Flush in cycle 3 of a refill; the retry must still miss and assemble clean data.
    c = cyc;
    req_i = 1'b1; pc_i = 32'h1000;
    exp_mem.push_back('{c + 1, 32'h1000});
    exp_mem.push_back('{c + 2, 32'h1001});
    step(); step(); step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    run_fill(32'h1000, INST_1000, SCHED_COLD, 6, -1, 0, -1, 0);

    req_i = 1'b1; pc_i = 32'h1200;
    #1;
    check("evicted_1200_miss", {31'b0, hit_o}, 32'h0);
    req_i = 1'b0;
    step(); step(); step();
    check("exp_mem_drained", 32'(exp_mem.size()), 32'h0);
    check("exp_hit_drained", 32'(exp_hit.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
